// File: rtl/data_cache_pkg.sv
// Shared types, geometry constants and address-field helpers for the data cache.
`default_nettype none

package data_cache_pkg;

  localparam int ADDR_W     = 8;
  localparam int INDEX_W    = 3;
  localparam int OFFSET_W   = 2;
  localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
  localparam int BLOCK_W    = 32;
  localparam int MADDR_W    = ADDR_W - OFFSET_W;
  localparam int NUM_BLOCKS = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W-1:0];
  endfunction

  function automatic logic [MADDR_W-1:0] addr_block(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:OFFSET_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_cache_cache_ctrl_fsm.sv
// Miss-handling controller: state register, next-state logic and memory request outputs.
`default_nettype none

module cache_ctrl_fsm
  import data_cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               access,
  input  logic               hit,
  input  logic               victim_dirty,
  input  logic               mem_busywait,
  input  logic [MADDR_W-1:0] victim_addr,
  input  logic [MADDR_W-1:0] fetch_addr,
  output state_t             state,
  output logic               mem_read,
  output logic               mem_write,
  output logic [MADDR_W-1:0] mem_address
);

  state_t next_state;

  // Asynchronous reset aborts any miss in progress, dropping requests immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (access && !hit) begin
          next_state = victim_dirty ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        if (!mem_busywait) begin
          next_state = FETCH;
        end
      end
      FETCH: begin
        if (!mem_busywait) begin
          next_state = UPDATE;
        end
      end
      UPDATE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    case (state)
      WRITEBACK: begin
        mem_write   = 1'b1;
        mem_address = victim_addr;
      end
      FETCH: begin
        mem_read    = 1'b1;
        mem_address = fetch_addr;
      end
      default: begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache: 8 blocks x 4 bytes, 8-bit byte address.
`default_nettype none

module data_cache
  import data_cache_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               READ,
  input  logic               WRITE,
  input  logic [ADDR_W-1:0]  ADDRESS,
  input  logic [7:0]         WRITEDATA,
  output logic [7:0]         READDATA,
  output logic               BUSYWAIT,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic [MADDR_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0] MEM_READDATA,
  input  logic               MEM_BUSYWAIT
);

  logic [BLOCK_W-1:0]    data_mem [NUM_BLOCKS];
  logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid;
  logic [NUM_BLOCKS-1:0] dirty;
  logic [BLOCK_W-1:0]    fill_block;

  logic [TAG_W-1:0]      tag;
  logic [INDEX_W-1:0]    idx;
  logic [OFFSET_W-1:0]   offset;
  logic [4:0]            bit_base;
  logic                  access;
  logic                  hit;
  logic                  idle_hit;
  logic                  write_hit;
  state_t                state;

  assign tag      = addr_tag(ADDRESS);
  assign idx      = addr_index(ADDRESS);
  assign offset   = addr_offset(ADDRESS);
  assign bit_base = {offset, 3'b000};

  // A simultaneous READ and WRITE is treated as a write.
  assign access    = READ | WRITE;
  assign hit       = valid[idx] && (tag_mem[idx] == tag);
  assign idle_hit  = (state == IDLE) && hit;
  assign write_hit = RESET && WRITE && idle_hit;

  assign BUSYWAIT      = RESET && access && !idle_hit;
  assign READDATA      = (RESET && access && idle_hit) ? data_mem[idx][bit_base +: 8] : 8'h00;
  assign MEM_WRITEDATA = (state == WRITEBACK) ? data_mem[idx] : '0;

  cache_ctrl_fsm u_ctrl (
    .clk          (CLK),
    .rst_n        (RESET),
    .access       (access),
    .hit          (hit),
    .victim_dirty (dirty[idx]),
    .mem_busywait (MEM_BUSYWAIT),
    .victim_addr  ({tag_mem[idx], idx}),
    .fetch_addr   (addr_block(ADDRESS)),
    .state        (state),
    .mem_read     (MEM_READ),
    .mem_write    (MEM_WRITE),
    .mem_address  (MEM_ADDRESS)
  );

  // Fetched block is held here for one cycle and installed during UPDATE.
  always_ff @(posedge CLK) begin
    if (state == FETCH && !MEM_BUSYWAIT) begin
      fill_block <= MEM_READDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET && state == UPDATE) begin
      data_mem[idx] <= fill_block;
      tag_mem[idx]  <= tag;
    end else if (write_hit) begin
      data_mem[idx][bit_base +: 8] <= WRITEDATA;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid <= '0;
      dirty <= '0;
    end else if (state == UPDATE) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (write_hit) begin
      dirty[idx] <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache with a fixed-latency memory model.
`timescale 1ns/1ps
`default_nettype none

module tb_data_cache;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  logic [7:0]  lat;
  logic [7:0]  mcnt;
  int          total;
  int          passed;
  int          failed;
  int          n;

  always #5 CLK = ~CLK;

  data_cache dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  // Memory: busy as soon as a request appears, for 'lat' cycles, then one ready cycle.
  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mcnt < lat);

  always @(posedge CLK) begin
    if (!(MEM_READ || MEM_WRITE) || !MEM_BUSYWAIT) mcnt <= 8'd0;
    else mcnt <= mcnt + 8'd1;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy_low(input int budget, output int cycles);
    cycles = 0;
    while (BUSYWAIT === 1'b1 && cycles < budget) begin
      step();
      cycles = cycles + 1;
    end
  endtask

  task automatic wait_mem_write_low(input int budget, output int cycles);
    cycles = 0;
    while (MEM_WRITE === 1'b1 && cycles < budget) begin
      step();
      cycles = cycles + 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    total = 0; passed = 0; failed = 0;
    RESET = 1'b0; READ = 1'b0; WRITE = 1'b0;
    ADDRESS = 8'h00; WRITEDATA = 8'h00;
    MEM_READDATA = 32'h0; lat = 8'd5; mcnt = 8'd0;

    #1;
    check("rst_busywait",  32'(BUSYWAIT),  32'h0);
    check("rst_mem_read",  32'(MEM_READ),  32'h0);
    check("rst_mem_write", 32'(MEM_WRITE), 32'h0);
    check("rst_readdata",  32'(READDATA),  32'h0);
    step(); step();
    RESET = 1'b1;
    step();

    // Clean miss at 0x14, memory latency 5
    MEM_READDATA = 32'hDDCCBBAA; lat = 8'd5;
    READ = 1'b1; ADDRESS = 8'h14;
    #1;
    check("miss_busy_now", 32'(BUSYWAIT), 32'h1);
    step();
    check("fetch_mem_read",  32'(MEM_READ),    32'h1);
    check("fetch_mem_write", 32'(MEM_WRITE),   32'h0);
    check("fetch_mem_addr",  32'(MEM_ADDRESS), 32'h05);
    wait_busy_low(40, n);
    check("fetch_to_hit_cycles", 32'(n), 32'd7);
    check("fill_readdata_off0", 32'(READDATA), 32'hAA);

    // Read hit in the same block
    ADDRESS = 8'h17;
    #1;
    check("hit_busy",     32'(BUSYWAIT), 32'h0);
    check("hit_readdata", 32'(READDATA), 32'hDD);
    step();
    check("hit_no_mem_read", 32'(MEM_READ), 32'h0);

    // Write hit then read back
    READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h15; WRITEDATA = 8'h5A;
    #1;
    check("wr_hit_busy", 32'(BUSYWAIT), 32'h0);
    step();
    WRITE = 1'b0; READ = 1'b1;
    #1;
    check("wr_readback", 32'(READDATA), 32'h5A);

    // Conflict miss on dirty line: writeback then fetch, latency 2
    MEM_READDATA = 32'h44332211; lat = 8'd2;
    ADDRESS = 8'h35;
    #1;
    check("evict_busy_now", 32'(BUSYWAIT), 32'h1);
    step();
    check("wb_mem_write", 32'(MEM_WRITE),     32'h1);
    check("wb_mem_read",  32'(MEM_READ),      32'h0);
    check("wb_mem_addr",  32'(MEM_ADDRESS),   32'h05);
    check("wb_mem_data",  MEM_WRITEDATA,      32'hDDCC5AAA);
    wait_mem_write_low(40, n);
    check("wb_cycles", 32'(n), 32'd3);
    check("evict_fetch_mem_read", 32'(MEM_READ),    32'h1);
    check("evict_fetch_mem_addr", 32'(MEM_ADDRESS), 32'h0D);
    wait_busy_low(40, n);
    check("evict_fetch_to_hit_cycles", 32'(n), 32'd4);
    check("evict_readdata_off1", 32'(READDATA), 32'h22);

    // Refilled line is clean: another conflict goes straight to FETCH
    ADDRESS = 8'h15;
    step();
    check("clean_no_writeback", 32'(MEM_WRITE), 32'h0);
    check("clean_fetch",        32'(MEM_READ),  32'h1);

    // Reset asserted mid-FETCH
    #2;
    RESET = 1'b0;
    #1;
    check("abort_mem_read", 32'(MEM_READ), 32'h0);
    check("abort_busywait", 32'(BUSYWAIT), 32'h0);
    step();
    RESET = 1'b1;
    ADDRESS = 8'h35;
    #1;
    check("abort_line_invalid", 32'(BUSYWAIT), 32'h1);
    wait_busy_low(40, n);
    check("abort_refill_readdata", 32'(READDATA), 32'h22);

    // READ and WRITE together at 0x00 behave as a write
    MEM_READDATA = 32'h00000000; lat = 8'd1;
    READ = 1'b1; WRITE = 1'b1; ADDRESS = 8'h00; WRITEDATA = 8'h11;
    #1;
    check("rw_busy_now", 32'(BUSYWAIT), 32'h1);
    step();
    check("rw_fetch_mem_read",  32'(MEM_READ),  32'h1);
    check("rw_fetch_mem_write", 32'(MEM_WRITE), 32'h0);
    wait_busy_low(40, n);
    step();
    WRITE = 1'b0;
    #1;
    check("rw_byte0", 32'(READDATA), 32'h11);
    ADDRESS = 8'h20;
    step();
    check("rw_dirty_wb",      32'(MEM_WRITE),     32'h1);
    check("rw_dirty_wb_addr", 32'(MEM_ADDRESS),   32'h00);
    check("rw_dirty_wb_data", MEM_WRITEDATA,      32'h00000011);
    wait_busy_low(40, n);
    READ = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
